filtr_sampler: RTL and testbench



---
 rtl/filtr_sampler_pkg.sv | 19 +
 rtl/filtr_rate_gen.sv | 29 ++
 rtl/filtr_sampler.sv | 123 ++++++++++++
 tb/tb_filtr_sampler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filtr_sampler_pkg.sv
// Shared FSM encoding and default sizes for the sample-rate sequencer and the filter top.
package filtr_sampler_pkg;

  localparam int DEF_DATA_SIZE = 24;
  localparam int DEF_DIV       = 2083;
  localparam int DEF_TIMEOUT   = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRIG = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  // Width of a counter that spans 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/filtr_rate_gen.sv
// Free-running 0..DIV-1 counter that emits a one-cycle tick on its last count.
module filtr_rate_gen
  import filtr_sampler_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int CW = cnt_width(DIV);

  logic [CW-1:0] r_count;

  assign o_tick = (r_count == CW'(DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (o_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/filtr_sampler.sv
// Paces the filter core: holds the newest ADC word, strikes sample on each rate tick, returns the result.
// Optional BUSY watchdog is built only when FILTR_SAMPLER_TIMEOUT_EN is defined.
module filtr_sampler
  import filtr_sampler_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int DIV       = DEF_DIV,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] adc_data,
  input  logic                 adc_valid,
  output logic                 sample,
  output logic [DATA_SIZE-1:0] filt_data,
  input  logic                 filter_done,
  input  logic [DATA_SIZE-1:0] filt_result,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 clr_flags,
  output logic                 overrun,
  output logic                 timeout
);

  state_t               r_state;
  logic [DATA_SIZE-1:0] r_hold;
  logic [DATA_SIZE-1:0] r_filt;
  logic [DATA_SIZE-1:0] r_out_data;
  logic                 r_sample;
  logic                 r_out_valid;
  logic                 r_overrun;
  logic                 w_tick;
  logic [DATA_SIZE-1:0] w_word;
  logic                 w_busy_expired;

  filtr_rate_gen #(.DIV(DIV)) u_rate_gen (
    .clk    (clk),
    .reset  (reset),
    .o_tick (w_tick)
  );

  // A word arriving on the tick cycle itself is the one that gets filtered.
  assign w_word = adc_valid ? adc_data : r_hold;

`ifdef FILTR_SAMPLER_TIMEOUT_EN
  localparam int TW = cnt_width(TIMEOUT);

  logic [TW-1:0] r_busy_cnt;
  logic          r_timeout;

  assign w_busy_expired = (r_state == ST_BUSY) && !filter_done &&
                          (r_busy_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_busy_cnt <= (r_state == ST_BUSY) ? r_busy_cnt + 1'b1 : '0;
      if (clr_flags)      r_timeout <= 1'b0;
      if (w_busy_expired) r_timeout <= 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_timeout;

  assign w_busy_expired   = 1'b0;
  assign w_unused_timeout = (TIMEOUT < 1) | w_busy_expired;
  assign timeout          = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_hold      <= '0;
      r_filt      <= '0;
      r_out_data  <= '0;
      r_sample    <= 1'b0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (adc_valid) r_hold <= adc_data;
      r_sample <= 1'b0;
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      // Later assignments win, so flag sets below override this clear.
      if (clr_flags) r_overrun <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          if (w_tick) begin
            r_filt   <= w_word;
            r_sample <= 1'b1;
            r_state  <= ST_TRIG;
          end
        end
        ST_TRIG: r_state <= ST_BUSY;
        ST_BUSY: begin
          if (filter_done) begin
            r_out_data  <= filt_result;
            r_out_valid <= 1'b1;
            if (r_out_valid && !out_ready) r_overrun <= 1'b1;
            r_state <= ST_IDLE;
          end else if (w_busy_expired) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_tick && (r_state != ST_IDLE)) r_overrun <= 1'b1;
    end
  end

  assign sample    = r_sample;
  assign filt_data = r_filt;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_filtr_sampler.sv
// Scoreboard bench for filtr_sampler with DIV=16 and a stub filter that returns filt_data ^ 24'h5A5A5A.
`timescale 1ns/1ps
module tb_filtr_sampler;

  localparam int DW = 24;
  localparam logic [DW-1:0] KEY = 24'h5A5A5A;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] adc_data;
  logic          adc_valid;
  logic          sample;
  logic [DW-1:0] filt_data;
  logic          filter_done;
  logic [DW-1:0] filt_result;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          clr_flags;
  logic          overrun;
  logic          timeout;

  logic m_done, s_done, done_en;
  int   lat;
  int   cyc;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   first_valid_cyc;
  logic prev_sample = 1'b0;
  logic prev_valid  = 1'b0;

  logic [DW-1:0] exp_filt[$];
  logic [DW-1:0] exp_res[$];
  int            samp_cyc[$];

  assign filter_done = m_done | s_done;

  filtr_sampler #(.DATA_SIZE(DW), .DIV(16), .TIMEOUT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .sample      (sample),
    .filt_data   (filt_data),
    .filter_done (filter_done),
    .filt_result (filt_result),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .clr_flags   (clr_flags),
    .overrun     (overrun),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Cycle index: number of rising edges since reset release.
  always @(posedge clk) begin
    if (reset) cyc = 0;
    else       cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stub filter: answers lat cycles after the strike with the word it is still being shown.
  initial begin
    m_done = 1'b0;
    filt_result = '0;
    forever begin
      @(negedge clk);
      if (sample && done_en) begin
        repeat (lat) @(posedge clk);
        #1;
        m_done = 1'b1;
        filt_result = filt_data ^ KEY;
        @(posedge clk);
        #1;
        m_done = 1'b0;
      end
    end
  end

  // Monitor: strikes against expected filter inputs, accepted outputs against expected results.
  always @(negedge clk) begin
    if (!reset && sample) begin
      samp_cyc.push_back(cyc);
      check("sample_single_cycle", 32'(prev_sample), 32'd0);
      if (exp_filt.size() == 0) check("sample_unexpected", 32'(sample), 32'd0);
      else                      check("filt_data", 32'(filt_data), 32'(exp_filt.pop_front()));
    end
    prev_sample = sample;
    if (!reset && out_valid && out_ready) begin
      if (exp_res.size() == 0) check("output_unexpected", 32'(out_valid), 32'd0);
      else                     check("out_data", 32'(out_data), 32'(exp_res.pop_front()));
    end
    if (out_valid && !prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    prev_valid = out_valid;
  end

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int c);
    wait_to(c);
    @(negedge clk);
  endtask

  task automatic pulse_adc(input logic [DW-1:0] d);
    adc_data  = d;
    adc_valid = 1'b1;
    @(posedge clk);
    #1;
    adc_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    adc_valid = 1'b0;
    clr_flags = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_filt_data", 32'(filt_data), 32'd0);
    check("rst_flags", {30'd0, overrun, timeout}, 32'd0);
    samp_cyc.delete();
    first_valid_cyc = -1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic end_phase(input string name);
    check({name, "_filt_left"}, 32'(exp_filt.size()), 32'd0);
    check({name, "_res_left"}, 32'(exp_res.size()), 32'd0);
  endtask

  function automatic int samp_at(input int i);
    return (samp_cyc.size() > i) ? samp_cyc[i] : -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; adc_data = '0; adc_valid = 1'b0; out_ready = 1'b1;
    clr_flags = 1'b0; s_done = 1'b0; done_en = 1'b1; lat = 5;
    cyc = 0; first_valid_cyc = -1;

    // Basic sample/result path and its timing.
    do_reset();
    exp_filt.push_back(24'h123456);
    exp_res.push_back(24'h486E0C);
    wait_to(2); pulse_adc(24'h123456);
    at_neg(23);
    check("p1_first_sample_cyc", 32'(samp_at(0)), 32'd16);
    check("p1_first_valid_cyc", 32'(first_valid_cyc), 32'd22);
    check("p1_valid_cleared", 32'(out_valid), 32'd0);
    at_neg(30);
    check("p1_overrun", 32'(overrun), 32'd0);
    check("p1_timeout", 32'(timeout), 32'd0);
    end_phase("p1");

    // Unaccepted result overwritten by the next one; flags cleared afterwards.
    do_reset();
    out_ready = 1'b0;
    exp_filt.push_back(24'h111111);
    exp_filt.push_back(24'h222222);
    exp_res.push_back(24'h787878);
    wait_to(2); pulse_adc(24'h111111);
    wait_to(20); pulse_adc(24'h222222);
    at_neg(30);
    check("p2_overrun_before", 32'(overrun), 32'd0);
    check("p2_first_held", 32'(out_data), 32'h4B4B4B);
    at_neg(40);
    check("p2_overrun_set", 32'(overrun), 32'd1);
    check("p2_valid_held", 32'(out_valid), 32'd1);
    check("p2_overwritten", 32'(out_data), 32'h787878);
    wait_to(41); out_ready = 1'b1;
    at_neg(43);
    check("p2_valid_cleared", 32'(out_valid), 32'd0);
    wait_to(44); clr_flags = 1'b1;
    @(posedge clk); #1; clr_flags = 1'b0;
    @(negedge clk);
    check("p2_overrun_cleared", 32'(overrun), 32'd0);
    end_phase("p2");

    // Filter slower than the sample period: every other tick dropped.
    do_reset();
    lat = 20;
    exp_filt.push_back(24'h0ABCDE);
    exp_filt.push_back(24'h0ABCDE);
    exp_res.push_back(24'h50E684);
    exp_res.push_back(24'h50E684);
    wait_to(2); pulse_adc(24'h0ABCDE);
    wait_to(31); clr_flags = 1'b1;
    @(posedge clk); #1; clr_flags = 1'b0;
    @(negedge clk);
    check("p3_set_beats_clear", 32'(overrun), 32'd1);
    at_neg(75);
    check("p3_sample_count", 32'(samp_cyc.size()), 32'd2);
    check("p3_sample_spacing", 32'(samp_at(1) - samp_at(0)), 32'd32);
    check("p3_timeout_quiet", 32'(timeout), 32'd0);
    end_phase("p3");

    // Hold register reused, then a word arriving on the tick cycle.
    do_reset();
    lat = 5;
    repeat (3) begin
      exp_filt.push_back(24'h00000A);
      exp_res.push_back(24'h5A5A50);
    end
    exp_filt.push_back(24'hC0FFEE);
    exp_res.push_back(24'h9AA5B4);
    wait_to(2); pulse_adc(24'h00000A);
    wait_to(63); pulse_adc(24'hC0FFEE);
    at_neg(74);
    check("p4_sample_count", 32'(samp_cyc.size()), 32'd4);
    check("p4_overrun", 32'(overrun), 32'd0);
    end_phase("p4");

`ifdef FILTR_SAMPLER_TIMEOUT_EN
    // Filter never answers: watchdog aborts BUSY, late done ignored.
    do_reset();
    done_en = 1'b0;
    exp_filt.push_back(24'h0000FF);
    exp_filt.push_back(24'h0000FF);
    wait_to(2); pulse_adc(24'h0000FF);
    at_neg(24);
    check("p5_timeout_before", 32'(timeout), 32'd0);
    at_neg(25);
    check("p5_timeout_set", 32'(timeout), 32'd1);
    wait_to(28); s_done = 1'b1;
    @(posedge clk); #1; s_done = 1'b0;
    at_neg(40);
    check("p5_second_sample_cyc", 32'(samp_at(1)), 32'd32);
    check("p5_overrun", 32'(overrun), 32'd0);
    check("p5_no_result", 32'(out_valid), 32'd0);
    at_neg(44);
    end_phase("p5");
    done_en = 1'b1;
`endif

    // Reset during BUSY with a result still in flight.
    do_reset();
    lat = 20;
    exp_filt.push_back(24'h55AA55);
    wait_to(2); pulse_adc(24'h55AA55);
    at_neg(33);
    check("p6_overrun_pre", 32'(overrun), 32'd1);
    wait_to(34);
    reset = 1'b1;
    #1;
    check("p6_rst_sample", 32'(sample), 32'd0);
    check("p6_rst_valid", 32'(out_valid), 32'd0);
    check("p6_rst_flags", {30'd0, overrun, timeout}, 32'd0);
    check("p6_rst_filt", 32'(filt_data), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    at_neg(4);
    check("p6_late_done_ignored", 32'(out_valid), 32'd0);
    at_neg(12);
    check("p6_no_sample", 32'(samp_cyc.size()), 32'd1);
    end_phase("p6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
